// File: rtl/cd_ext_host.sv
// cd_ext_host: EXT_BUS CD command initiator running CD_GET/CD_SET sequences.
// Optional automatic polling of CD status when CD_EXT_HOST_AUTOPOLL_EN is defined.
module cd_ext_host #(
  parameter int STROBE_GAP = 1,
  parameter int POLL_DIV   = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  output logic        ext_enable,
  output logic        ext_strobe,
  output logic [15:0] ext_dout,
  input  logic [15:0] ext_din,
  input  logic        ext_dout_en,
  input  logic        set_valid,
  output logic        set_ready,
  input  logic [47:0] set_data,
  input  logic        get_req,
  input  logic        poll_en,
  output logic        rx_valid,
  output logic [47:0] rx_data,
  output logic [7:0]  rx_seq,
  output logic        err,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, GAP, CLOSE} state_t;
  state_t state, state_n;
  logic        cmd_set, get_pend, early, last_vld, poll_hit;
  logic [47:0] set_buf, rx_buf;
  logic [7:0]  seq_buf, last_seq;
  logic [1:0]  idx;
  logic [15:0] gap_cnt;
  logic        first_gap, gap_done, word0_get, no_claim, seq_same, start_get, get_done;
  assign first_gap = state == GAP && gap_cnt == 16'd0;
  assign gap_done  = state == GAP && gap_cnt == 16'(STROBE_GAP - 1);
  assign word0_get = first_gap && idx == 2'd0 && !cmd_set;
  assign no_claim  = word0_get && !ext_dout_en;
  assign seq_same  = word0_get && ext_dout_en && last_vld && ext_din[7:0] == last_seq;
  assign start_get = state == IDLE && !set_valid && (get_pend || get_req);
  assign get_done  = gap_done && idx == 2'd3 && !cmd_set;
`ifdef CD_EXT_HOST_AUTOPOLL_EN
  logic [31:0] poll_cnt;
  always_ff @(posedge clk_sys)
    if (reset || !poll_en) poll_cnt <= '0;
    else poll_cnt <= poll_cnt == 32'(POLL_DIV - 1) ? '0 : poll_cnt + 32'd1;
  assign poll_hit = poll_en && poll_cnt == 32'(POLL_DIV - 1);
`else
  logic unused_poll;
  assign unused_poll = poll_en;
  assign poll_hit = 1'b0;
`endif
  always_ff @(posedge clk_sys)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (set_valid || get_pend || get_req) ? SETUP : IDLE;
      SETUP:   state_n = STROBE;
      STROBE:  state_n = GAP;
      GAP:     state_n = no_claim ? CLOSE : !gap_done ? GAP :
                         (idx == 2'd3 || seq_same || early) ? CLOSE : STROBE;
      CLOSE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    ext_enable = state == SETUP || state == STROBE || state == GAP;
    ext_strobe = state == STROBE;
    ext_dout   = !ext_strobe ? 16'h0 :
                 idx == 2'd0 ? (cmd_set ? 16'h0035 : 16'h0034) :
                 !cmd_set    ? 16'h0 :
                 idx == 2'd1 ? set_buf[15:0] :
                 idx == 2'd2 ? set_buf[31:16] : set_buf[47:32];
    set_ready  = state == IDLE && !reset;
    busy       = state != IDLE;
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      cmd_set  <= 1'b0;
      get_pend <= 1'b0;
      early    <= 1'b0;
      last_vld <= 1'b0;
      set_buf  <= '0;
      rx_buf   <= '0;
      seq_buf  <= '0;
      last_seq <= '0;
      idx      <= '0;
      gap_cnt  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_seq   <= '0;
      err      <= 1'b0;
    end else begin
      rx_valid <= get_done;
      err      <= no_claim;
      get_pend <= (get_pend || get_req || poll_hit) && !start_get;
      if (state == IDLE && set_valid) begin
        cmd_set <= 1'b1;
        set_buf <= set_data;
      end else if (start_get) cmd_set <= 1'b0;
      if (state == SETUP) begin
        idx   <= '0;
        early <= 1'b0;
      end
      if (state == STROBE) gap_cnt <= '0;
      if (state == GAP) gap_cnt <= gap_cnt + 16'd1;
      if (gap_done) idx <= idx + 2'd1;
      if (first_gap)
        case (idx)
          2'd0: begin
            seq_buf <= ext_din[7:0];
            early   <= seq_same;
          end
          2'd1: rx_buf[15:0]  <= ext_din;
          2'd2: rx_buf[31:16] <= ext_din;
          default: rx_buf[47:32] <= ext_din;
        endcase
      // with a one-cycle gap, word 3 arrives in the same cycle the transaction completes
      if (get_done) begin
        rx_data  <= {first_gap ? ext_din : rx_buf[47:32], rx_buf[31:0]};
        rx_seq   <= seq_buf;
        last_seq <= seq_buf;
        last_vld <= 1'b1;
      end
    end
endmodule
